// File: rtl/id_ex_stage_if.sv
// ID->EX stage bundle: decode fields, regfile read data, forwarding sources, EX outputs and stall.
// master drives decode/forwarding inputs; slave is the pipeline register itself.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [31:0]               id_pc;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_usesRs1;
    logic                      id_usesRs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [3:0]                id_aluOp;
    logic                      id_aluSrc;
    logic                      id_memRead;
    logic                      id_memWrite;
    logic                      id_regWrite;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     regReadDataA;
    logic [DATA_WIDTH-1:0]     regReadDataB;
    logic                      mem_regWrite;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_memRead;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic                      wb_regWrite;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic                      ex_valid;
    logic [31:0]               ex_pc;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [3:0]                ex_aluOp;
    logic                      ex_memRead;
    logic                      ex_memWrite;
    logic                      ex_regWrite;
    logic [DATA_WIDTH-1:0]     ex_opA;
    logic [DATA_WIDTH-1:0]     ex_opB;
    logic [DATA_WIDTH-1:0]     ex_storeData;
    logic                      stall;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_usesRs1, id_usesRs2, id_rd, id_imm,
               id_aluOp, id_aluSrc, id_memRead, id_memWrite, id_regWrite, flush,
               regReadDataA, regReadDataB, mem_regWrite, mem_rd, mem_memRead, mem_result,
               wb_regWrite, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rd, ex_imm, ex_aluOp, ex_memRead, ex_memWrite, ex_regWrite,
               ex_opA, ex_opB, ex_storeData, stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_usesRs1, id_usesRs2, id_rd, id_imm,
               id_aluOp, id_aluSrc, id_memRead, id_memWrite, id_regWrite, flush,
               regReadDataA, regReadDataB, mem_regWrite, mem_rd, mem_memRead, mem_result,
               wb_regWrite, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rd, ex_imm, ex_aluOp, ex_memRead, ex_memWrite, ex_regWrite,
               ex_opA, ex_opB, ex_storeData, stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Latency: 1 cycle ID->EX; operands are combinational from registered state plus forwarding inputs.
// Backpressure: combinational stall holds IF/ID for one cycle on load-use; flush/stall load a bubble.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic                      valid;
        logic [31:0]               pc;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic                      uses_rs1;
        logic                      uses_rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     imm;
        logic [3:0]                alu_op;
        logic                      alu_src;
        logic                      mem_read;
        logic                      mem_write;
        logic                      reg_write;
    } ex_reg_t;

    ex_reg_t               ex_q;
    logic                  stall_int;
    logic                  fwd_mem_a, fwd_mem_b;
    logic                  fwd_wb_a, fwd_wb_b;
    logic [DATA_WIDTH-1:0] op_a, op_b_reg;

    // Load in EX whose rd feeds the decode instruction; a flush kills decode, so no stall then.
    assign stall_int = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && !bus.flush &&
                       ((bus.id_usesRs1 && (bus.id_rs1 == ex_q.rd)) ||
                        (bus.id_usesRs2 && (bus.id_rs2 == ex_q.rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush || stall_int) begin
            ex_q.valid     <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
            ex_q.reg_write <= 1'b0;
        end else begin
            ex_q.valid     <= bus.id_valid;
            ex_q.pc        <= bus.id_pc;
            ex_q.rs1       <= bus.id_rs1;
            ex_q.rs2       <= bus.id_rs2;
            ex_q.uses_rs1  <= bus.id_usesRs1;
            ex_q.uses_rs2  <= bus.id_usesRs2;
            ex_q.rd        <= bus.id_rd;
            ex_q.imm       <= bus.id_imm;
            ex_q.alu_op    <= bus.id_aluOp;
            ex_q.alu_src   <= bus.id_aluSrc;
            ex_q.mem_read  <= bus.id_valid && bus.id_memRead;
            ex_q.mem_write <= bus.id_valid && bus.id_memWrite;
            ex_q.reg_write <= bus.id_valid && bus.id_regWrite;
        end
    end

    // x0 is never forwarded: the regfile already returns zero for it.
    assign fwd_mem_a = bus.mem_regWrite && (bus.mem_rd == ex_q.rs1) && (ex_q.rs1 != '0);
    assign fwd_mem_b = bus.mem_regWrite && (bus.mem_rd == ex_q.rs2) && (ex_q.rs2 != '0);
    assign fwd_wb_a  = bus.wb_regWrite  && (bus.wb_rd  == ex_q.rs1) && (ex_q.rs1 != '0);
    assign fwd_wb_b  = bus.wb_regWrite  && (bus.wb_rd  == ex_q.rs2) && (ex_q.rs2 != '0);

    always_comb begin
        op_a = bus.regReadDataA;
        if (fwd_mem_a)     op_a = bus.mem_result;
        else if (fwd_wb_a) op_a = bus.wb_data;
    end

    always_comb begin
        op_b_reg = bus.regReadDataB;
        if (fwd_mem_b)     op_b_reg = bus.mem_result;
        else if (fwd_wb_b) op_b_reg = bus.wb_data;
    end

    assign bus.stall        = stall_int;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_aluOp     = ex_q.alu_op;
    assign bus.ex_memRead   = ex_q.mem_read;
    assign bus.ex_memWrite  = ex_q.mem_write;
    assign bus.ex_regWrite  = ex_q.reg_write;
    assign bus.ex_opA       = op_a;
    assign bus.ex_storeData = op_b_reg;
    assign bus.ex_opB       = ex_q.alu_src ? ex_q.imm : op_b_reg;

`ifndef SYNTHESIS
    // A load's MEM-stage result is an address, not data; the stall rule keeps consumers out of EX.
    a_no_load_fwd_from_mem: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_q.valid && bus.mem_memRead &&
          ((fwd_mem_a && ex_q.uses_rs1) || (fwd_mem_b && ex_q.uses_rs2))));
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Random instruction stream through a bench-owned EX/MEM/WB pipeline; expected operands come
// from a program-order architectural register model, checked by a scoreboard monitor.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        bit        valid;
        bit [31:0] pc;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit        u1;
        bit        u2;
        bit [4:0]  rd;
        bit [31:0] imm;
        bit [3:0]  op;
        bit        src;
        bit        mr;
        bit        mw;
        bit        rw;
        bit [31:0] result;
        bit [31:0] junk;
    } ins_t;

    typedef struct packed {
        ins_t      i;
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] sd;
    } exp_t;

    exp_t      sbq[$];
    exp_t      mon_e;
    int        total = 0;
    int        bad = 0;
    bit        mon_on = 1'b0;
    ins_t      id_i, ex_m, mem_m, wb_m;
    bit [31:0] retired[32];
    bit [31:0] arch[32];
    bit        flush_v;
    bit        st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit [4:0] pick_reg();
        if ($urandom % 4 == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    function automatic ins_t gen_ins();
        ins_t n;
        n.valid  = ($urandom % 8) != 0;
        n.pc     = $urandom;
        n.rs1    = pick_reg();
        n.rs2    = pick_reg();
        n.u1     = ($urandom % 4) != 0;
        n.u2     = ($urandom % 2) != 0;
        n.rd     = pick_reg();
        n.imm    = $urandom;
        n.op     = 4'($urandom);
        n.src    = ($urandom % 2) != 0;
        n.mr     = ($urandom % 3) == 0;
        n.mw     = !n.mr && (($urandom % 4) == 0);
        n.rw     = n.mr || (!n.mw && (($urandom % 4) != 0));
        n.result = $urandom;
        n.junk   = $urandom;
        return n;
    endfunction

    task automatic drive_inputs();
        bus.id_valid     = id_i.valid;
        bus.id_pc        = id_i.pc;
        bus.id_rs1       = id_i.rs1;
        bus.id_rs2       = id_i.rs2;
        bus.id_usesRs1   = id_i.u1;
        bus.id_usesRs2   = id_i.u2;
        bus.id_rd        = id_i.rd;
        bus.id_imm       = id_i.imm;
        bus.id_aluOp     = id_i.op;
        bus.id_aluSrc    = id_i.src;
        bus.id_memRead   = id_i.mr;
        bus.id_memWrite  = id_i.mw;
        bus.id_regWrite  = id_i.rw;
        bus.flush        = flush_v;
        bus.regReadDataA = retired[ex_m.rs1];
        bus.regReadDataB = retired[ex_m.rs2];
        bus.mem_regWrite = mem_m.valid && mem_m.rw;
        bus.mem_rd       = mem_m.rd;
        bus.mem_memRead  = mem_m.valid && mem_m.mr;
        bus.mem_result   = mem_m.mr ? mem_m.junk : mem_m.result;
        bus.wb_regWrite  = wb_m.valid && wb_m.rw;
        bus.wb_rd        = wb_m.rd;
        bus.wb_data      = wb_m.result;
    endtask

    function automatic bit exp_stall();
        return id_i.valid && ex_m.valid && ex_m.mr && (ex_m.rd != 0) && !flush_v &&
               ((id_i.u1 && id_i.rs1 == ex_m.rd) || (id_i.u2 && id_i.rs2 == ex_m.rd));
    endfunction

    task automatic clear_model();
        id_i = '0; ex_m = '0; mem_m = '0; wb_m = '0; flush_v = 1'b0;
        for (int r = 0; r < 32; r++) begin
            retired[r] = (r == 0) ? 32'h0 : $urandom;
            arch[r]    = retired[r];
        end
    endtask

    // One clock edge of the reference pipeline: retire WB, shift, then accept or bubble.
    task automatic step_model(input bit stall_now);
        exp_t e;
        if (wb_m.valid && wb_m.rw && wb_m.rd != 0) retired[wb_m.rd] = wb_m.result;
        wb_m  = mem_m;
        mem_m = ex_m;
        if (flush_v || stall_now) begin
            ex_m.valid = 1'b0; ex_m.mr = 1'b0; ex_m.mw = 1'b0; ex_m.rw = 1'b0;
        end else begin
            ex_m = id_i;
            if (!id_i.valid) begin
                ex_m.mr = 1'b0; ex_m.mw = 1'b0; ex_m.rw = 1'b0;
            end else begin
                e.i  = id_i;
                e.a  = arch[id_i.rs1];
                e.sd = arch[id_i.rs2];
                e.b  = id_i.src ? id_i.imm : e.sd;
                sbq.push_back(e);
                if (id_i.rw && id_i.rd != 0) arch[id_i.rd] = id_i.result;
            end
        end
        if (!stall_now) id_i = gen_ins();
        flush_v = ($urandom % 10) == 0;
    endtask

    always @(negedge clk) begin
        if (mon_on && rst_n && bus.ex_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ex_valid: got ex_valid=1 expected no pending instruction");
            end else begin
                mon_e = sbq.pop_front();
                chk("ex_pc", bus.ex_pc, mon_e.i.pc);
                chk("ex_rd", 32'(bus.ex_rd), 32'(mon_e.i.rd));
                chk("ex_imm", bus.ex_imm, mon_e.i.imm);
                chk("ex_ctrl", {28'h0, bus.ex_memRead, bus.ex_memWrite, bus.ex_regWrite, 1'b0},
                    {28'h0, mon_e.i.mr, mon_e.i.mw, mon_e.i.rw, 1'b0});
                chk("ex_aluOp", 32'(bus.ex_aluOp), 32'(mon_e.i.op));
                if (mon_e.i.u1) chk("ex_opA", bus.ex_opA, mon_e.a);
                if (mon_e.i.src || mon_e.i.u2) chk("ex_opB", bus.ex_opB, mon_e.b);
                if (mon_e.i.u2) chk("ex_storeData", bus.ex_storeData, mon_e.sd);
            end
        end
    end

    initial begin
        clear_model();
        drive_inputs();
        #12;
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        chk("reset_ex_ctrl", {29'h0, bus.ex_memRead, bus.ex_memWrite, bus.ex_regWrite}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw x7 enters EX, dependent add in decode, then reset lands mid-cycle during the stall
        id_i.valid = 1'b1; id_i.mr = 1'b1; id_i.rw = 1'b1; id_i.rd = 5'd7;
        drive_inputs();
        @(posedge clk);
        #1;
        id_i = '0; id_i.valid = 1'b1; id_i.rs1 = 5'd7; id_i.u1 = 1'b1; id_i.rd = 5'd8; id_i.rw = 1'b1;
        drive_inputs();
        #2;
        chk("loaduse_stall", 32'(bus.stall), 32'h1);
        chk("load_in_ex", 32'(bus.ex_memRead), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("async_reset_stall", 32'(bus.stall), 32'h0);

        @(negedge clk);
        clear_model();
        id_i = gen_ins();
        drive_inputs();
        st = exp_stall();
        mon_on = 1'b1;
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            step_model(st);
            #1;
            drive_inputs();
            st = exp_stall();
            #3;
            chk("stall", 32'(bus.stall), 32'(st));
            chk("ex_valid", 32'(bus.ex_valid), 32'(ex_m.valid));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
